mcif_wr_arb: RTL



---
 rtl/mcif_wr_arb_pkg.sv | 27 ++
 rtl/mcif_wr_ost_fifo.sv | 51 +++++
 rtl/mcif_wr_arb.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mcif_wr_arb_pkg.sv
// Shared constants, FSM encoding and helpers for the MCIF write-request arbiter.
package mcif_wr_arb_pkg;

  localparam int LEN_LSB   = 32;
  localparam int DEF_LEN_W = 4;
  localparam int DEF_DAT_W = 32;
  localparam int DEF_PD_W  = 2 + DEF_LEN_W + 32 + DEF_DAT_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  function automatic int cmd_flag_bit(input int pd_w);
    return pd_w - 1;
  endfunction

  function automatic int np_bit(input int len_w);
    return LEN_LSB + len_w;
  endfunction

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mcif_wr_ost_fifo.sv
// Requester-ID FIFO for outstanding non-posted writes; push and pop may coincide,
// and a push while full is accepted only when a pop frees the head in the same cycle.
module mcif_wr_ost_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/mcif_wr_arb.sv
// Round-robin burst-locked arbiter for the MCIF write channel; routes non-posted
// completions back to the issuing requester. Data path is combinational.
module mcif_wr_arb
  import mcif_wr_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int LEN_W     = DEF_LEN_W,
  parameter int PD_W      = DEF_PD_W,
  parameter int OST_DEPTH = 8,
  localparam int ID_W     = id_width(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_vld,
  input  logic [NUM_REQ*PD_W-1:0] req_pd,
  output logic [NUM_REQ-1:0]      req_rdy,
  output logic [NUM_REQ-1:0]      req_rsp_complete,
  output logic                    mcif_wr_req_vld,
  input  logic                    mcif_wr_req_rdy,
  output logic [PD_W-1:0]         mcif_wr_req_pd,
  input  logic                    mcif_wr_rsp_complete,
  output logic [ID_W-1:0]         grant_id,
  output logic                    err_proto
);
  localparam int CMD_BIT = cmd_flag_bit(PD_W);
  localparam int NPB     = np_bit(LEN_W);

  arb_state_e         state_q, state_d;
  logic [ID_W-1:0]    grant_q, grant_d, last_grant_q, last_grant_d;
  logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               err_q, err_d;
  logic [NUM_REQ-1:0] rsp_q, rsp_d;

  logic [NUM_REQ-1:0] elig;
  logic               pick_vld;
  logic [ID_W-1:0]    pick_id;
  logic [PD_W-1:0]    g_pd;
  logic               g_vld, g_is_cmd, g_np, hs;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ID_W-1:0]    fifo_head;

  // Non-posted commands are held back while there is no room to track them.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_vld[i] && req_pd[i*PD_W + CMD_BIT] &&
                (!req_pd[i*PD_W + NPB] || !fifo_full);
    end
  end

  always_comb begin
    int idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant_q) + k) % NUM_REQ;
      if (!pick_vld && elig[idx]) begin
        pick_vld = 1'b1;
        pick_id  = ID_W'(idx);
      end
    end
  end

  assign g_pd     = req_pd[int'(grant_q)*PD_W +: PD_W];
  assign g_vld    = req_vld[grant_q];
  assign g_is_cmd = g_pd[CMD_BIT];
  assign g_np     = g_pd[NPB];
  assign hs       = mcif_wr_req_vld && mcif_wr_req_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pick_vld) state_d = ST_CMD;
      ST_CMD:  if (hs) state_d = ST_DATA;
      ST_DATA: if (hs && beat_cnt_q == '0) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A beat of the wrong kind for the current phase is never presented to MCIF.
  always_comb begin
    req_rdy         = '0;
    mcif_wr_req_vld = 1'b0;
    mcif_wr_req_pd  = '0;
    case (state_q)
      ST_CMD: begin
        mcif_wr_req_pd   = g_pd;
        mcif_wr_req_vld  = g_vld && g_is_cmd;
        req_rdy[grant_q] = mcif_wr_req_rdy && g_is_cmd;
      end
      ST_DATA: begin
        mcif_wr_req_pd   = g_pd;
        mcif_wr_req_vld  = g_vld && !g_is_cmd;
        req_rdy[grant_q] = mcif_wr_req_rdy && !g_is_cmd;
      end
      default: ;
    endcase
  end

  assign fifo_push = (state_q == ST_CMD) && hs && g_np;
  assign fifo_pop  = mcif_wr_rsp_complete && !fifo_empty;

  always_comb begin
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    rsp_d        = '0;
    if (state_q == ST_IDLE && pick_vld) grant_d = pick_id;
    if (state_q == ST_CMD && hs) beat_cnt_d = g_pd[LEN_LSB +: LEN_W];
    if (state_q == ST_DATA && hs) begin
      beat_cnt_d = beat_cnt_q - LEN_W'(1);
      if (beat_cnt_q == '0) last_grant_d = grant_q;
    end
    if (fifo_pop) rsp_d[fifo_head] = 1'b1;
    err_d = err_q ||
            (state_q == ST_CMD  && g_vld && !g_is_cmd) ||
            (state_q == ST_DATA && g_vld &&  g_is_cmd) ||
            (mcif_wr_rsp_complete && fifo_empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q      <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
      err_q        <= 1'b0;
      rsp_q        <= '0;
    end else begin
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      err_q        <= err_d;
      rsp_q        <= rsp_d;
    end
  end

  mcif_wr_ost_fifo #(
    .DEPTH (OST_DEPTH),
    .W     (ID_W)
  ) u_ost_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (fifo_push),
    .push_dat_i (grant_q),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign grant_id         = grant_q;
  assign err_proto        = err_q;
  assign req_rsp_complete = rsp_q;

endmodule
